// File: rtl/lsu_pkg.sv
// lsu_pkg: access-type codes, exception codes and FSM states shared by the LSU files
package lsu_pkg;
   localparam logic [2:0] DM_W  = 3'd0;
   localparam logic [2:0] DM_H  = 3'd1;
   localparam logic [2:0] DM_HU = 3'd2;
   localparam logic [2:0] DM_B  = 3'd3;
   localparam logic [2:0] DM_BU = 3'd4;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store-lane replication, load lane extraction/extension and misalign detection
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  typ,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic [1:0]  addr_fix,
   output logic        misaligned
);
   logic is_h, is_b;
   logic [15:0] lane_h;
   logic [7:0] lane_b;
   // codes 5-7 fall through every test below and behave as a word access
   always_comb begin
      is_h = typ == DM_H || typ == DM_HU;
      is_b = typ == DM_B || typ == DM_BU;
      lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
      lane_b = rdata[{addr, 3'b000} +: 8];
      be = is_b ? 4'b0001 << addr : is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
      rdata_ext = typ == DM_H  ? {{16{lane_h[15]}}, lane_h} :
                  typ == DM_HU ? {16'b0, lane_h} :
                  typ == DM_B  ? {{24{lane_b[7]}}, lane_b} :
                  typ == DM_BU ? {24'b0, lane_b} : rdata;
      addr_fix = is_b ? addr : is_h ? {addr[1], 1'b0} : 2'b00;
      misaligned = is_b ? 1'b0 : is_h ? addr[0] : addr != 2'b00;
   end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: one-at-a-time load/store initiator between the CPU memory stage and word memory.
// LSU_MISALIGN_EXC_EN: raise AdEL/AdES on misaligned accesses instead of silently aligning them.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [31:0]       req_pc,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_exc,
   output logic [4:0]        resp_exccode,
   output logic [31:0]       resp_pc,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_t state, state_nx;
   logic we_r, accept, to_exc, misaligned, idle;
   logic [2:0] typ_r;
   logic [ADDR_W-1:0] addr_r, addr_eff;
   logic [DATA_W-1:0] wdata_r, rdata_r, wdata_rep, rdata_ext;
   logic [31:0] pc_r;
   logic [3:0] be;
   logic [1:0] addr_fix;

   assign idle = state == IDLE;
   assign accept = idle && req_valid;

   // in IDLE the aligner judges the incoming request, afterwards the latched one
   lsu_align u_align (
      .typ        (idle ? req_type : typ_r),
      .addr       (idle ? req_addr[1:0] : addr_r[1:0]),
      .wdata      (wdata_r),
      .rdata      (mem_rdata),
      .be         (be),
      .wdata_rep  (wdata_rep),
      .rdata_ext  (rdata_ext),
      .addr_fix   (addr_fix),
      .misaligned (misaligned)
   );

   // forcing alignment only matters when misaligned accesses are allowed through
   assign addr_eff = {req_addr[ADDR_W-1:2], misaligned ? addr_fix : req_addr[1:0]};

`ifdef LSU_MISALIGN_EXC_EN
   logic exc_r;
   always_ff @(posedge clk)
      if (reset) exc_r <= 1'b0;
      else if (accept) exc_r <= misaligned;
   assign to_exc = misaligned;
   assign resp_exc = resp_valid && exc_r;
`else
   assign to_exc = 1'b0;
   assign resp_exc = 1'b0;
`endif

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      req_ready = 1'b0;
      mem_req_valid = 1'b0;
      resp_valid = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = to_exc ? RESP : ISSUE;
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nx = WAIT;
         end
         WAIT: if (mem_rsp_valid) state_nx = RESP;
         RESP: begin
            resp_valid = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) begin
         we_r <= 1'b0;
         typ_r <= DM_W;
         addr_r <= '0;
         wdata_r <= '0;
         pc_r <= '0;
         rdata_r <= '0;
      end else if (accept) begin
         we_r <= req_we;
         typ_r <= req_type;
         addr_r <= addr_eff;
         wdata_r <= req_wdata;
         pc_r <= req_pc;
         rdata_r <= '0;
      end else if (state == WAIT && mem_rsp_valid && !we_r) begin
         rdata_r <= rdata_ext;
      end

   assign mem_addr = mem_req_valid ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
   assign mem_we = mem_req_valid && we_r;
   assign mem_be = mem_req_valid ? be : 4'b0000;
   assign mem_wdata = mem_req_valid ? wdata_rep : '0;
   assign resp_rdata = resp_valid ? rdata_r : '0;
   assign resp_pc = resp_valid ? pc_r : '0;
   assign resp_exccode = resp_exc ? (we_r ? EXC_ADES : EXC_ADEL) : 5'd0;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: randomized scoreboard bench checking the LSU against a byte-addressed memory model
`timescale 1ns/1ps
module tb_lsu_mem_initiator;
   import lsu_pkg::*;
   logic clk = 1'b0, reset = 1'b1;
   logic req_valid = 1'b0, req_we = 1'b0;
   logic [2:0] req_type = 3'd0;
   logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
   logic req_ready, resp_valid, resp_exc, mem_req_valid, mem_we;
   logic [31:0] resp_rdata, resp_pc, mem_addr, mem_wdata;
   logic [4:0] resp_exccode;
   logic [3:0] mem_be;
   logic mem_req_ready, mem_rsp_valid;
   logic [31:0] mem_rdata;
   int tests = 0, fails = 0, cyc = 0;
   bit fast = 1'b1;
   int hold = 0, rsp_dly = 0;

   typedef struct {logic [31:0] rdata; logic exc; logic [4:0] code; logic [31:0] pc; int lat; int acc;} exp_t;
   typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} mexp_t;
   exp_t exp_q[$];
   mexp_t mexp_q[$];
   logic [7:0] rmem[int unsigned];
   logic [31:0] smem[int unsigned];

   lsu_mem_initiator dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_type(req_type),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
      .resp_exccode(resp_exccode), .resp_pc(resp_pc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] rb(input int unsigned a);
      return rmem.exists(a) ? rmem[a] : 8'h00;
   endfunction

   // reference: an access is `size` consecutive bytes, little-endian, in a flat byte memory
   task automatic do_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input bit tlat);
      int size, n;
      logic [31:0] ea, v;
      exp_t e;
      mexp_t m;
      size = (t == DM_H || t == DM_HU) ? 2 : (t == DM_B || t == DM_BU) ? 1 : 4;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!req_ready) begin
         fails++;
         $display("FAIL req_ready_timeout: got 0 expected 1 within 100 cycles");
         return;
      end
      e.pc = $urandom;
      e.acc = cyc;
      e.exc = 1'b0;
      e.code = 5'd0;
      e.rdata = '0;
      ea = a;
`ifdef LSU_MISALIGN_EXC_EN
      if (a % size != 0) begin
         e.exc = 1'b1;
         e.code = we ? 5'd5 : 5'd4;
      end
`else
      ea = a - a % size;
`endif
      e.lat = tlat ? (e.exc ? 1 : 3) : -1;
      if (!e.exc) begin
         m.addr = ea & ~32'd3;
         m.we = we;
         m.be = '0;
         m.wdata = '0;
         for (int i = 0; i < size; i++) m.be[(ea + i) % 4] = 1'b1;
         for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
         if (we) begin
            for (int i = 0; i < size; i++) rmem[ea + i] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rb(ea + i);
            if ((t == DM_H || t == DM_B) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            e.rdata = v;
         end
         mexp_q.push_back(m);
      end
      exp_q.push_back(e);
      req_valid = 1'b1;
      req_we = we;
      req_type = t;
      req_addr = a;
      req_wdata = wd;
      req_pc = e.pc;
      @(negedge clk);
      req_valid = 1'b0;
      req_we = $urandom_range(0, 1);
      req_type = 3'($urandom_range(0, 7));
      req_addr = $urandom;
      req_wdata = $urandom;
      req_pc = $urandom;
   endtask

   // memory slave: word array, checks each request against the expected request queue
   initial begin
      logic [31:0] a0, w0, rd, word;
      logic [3:0] b0;
      bit busy;
      int cnt;
      mexp_t m;
      busy = 1'b0;
      cnt = 0;
      rd = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rdata = rd;
            end
         end
         if (mem_req_valid) begin
            if (busy) begin
               chk("hold_mem_addr", mem_addr, a0);
               chk("hold_mem_be", {28'd0, mem_be}, {28'd0, b0});
               chk("hold_mem_wdata", mem_wdata, w0);
               chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end else begin
               busy = 1'b1;
               a0 = mem_addr;
               b0 = mem_be;
               w0 = mem_wdata;
            end
            mem_req_ready = hold > 0 ? 1'b0 : fast ? 1'b1 : 1'($urandom_range(0, 1));
            if (hold > 0) hold--;
            if (mem_req_ready) begin
               busy = 1'b0;
               if (mexp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL mem_req_unexpected: got request at %h expected none", mem_addr);
               end else begin
                  m = mexp_q.pop_front();
                  chk("mem_addr", mem_addr, m.addr);
                  chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                  chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
                  if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
               end
               word = smem.exists(mem_addr >> 2) ? smem[mem_addr >> 2] : 32'd0;
               if (mem_we) begin
                  for (int i = 0; i < 4; i++) if (mem_be[i]) word[8*i +: 8] = mem_wdata[8*i +: 8];
                  smem[mem_addr >> 2] = word;
               end
               rd = word;
               cnt = rsp_dly > 0 ? rsp_dly : fast ? 1 : $urandom_range(1, 3);
            end
         end else begin
            busy = 1'b0;
            mem_req_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && resp_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL resp_unexpected: got response pc %h expected none", resp_pc);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_exc", {31'd0, resp_exc}, {31'd0, e.exc});
            chk("resp_exccode", {27'd0, resp_exccode}, {27'd0, e.code});
            chk("resp_pc", resp_pc, e.pc);
            if (e.lat >= 0) chk("resp_latency", cyc - e.acc, e.lat);
         end
      end
   end

   initial begin
      int n;
      logic [31:0] a;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_resp_pc", resp_pc, 32'd0);
      reset = 1'b0;
      do_req(1'b1, DM_W, 32'h10, 32'hDEAD_BEEF, 1'b1);
      do_req(1'b0, DM_W, 32'h10, 32'h0, 1'b1);
      do_req(1'b1, DM_W, 32'h20, 32'h80FF_7F01, 1'b1);
      do_req(1'b0, DM_B, 32'h23, 32'h0, 1'b1);
      do_req(1'b0, DM_BU, 32'h23, 32'h0, 1'b1);
      do_req(1'b0, DM_B, 32'h21, 32'h0, 1'b1);
      do_req(1'b1, DM_H, 32'h32, 32'h1234_ABCD, 1'b1);
      do_req(1'b0, DM_H, 32'h32, 32'h0, 1'b1);
      do_req(1'b0, DM_HU, 32'h32, 32'h0, 1'b1);
      do_req(1'b1, DM_W, 32'h40, 32'hCAFE_F00D, 1'b1);
      do_req(1'b0, DM_W, 32'h41, 32'h0, 1'b1);
      do_req(1'b1, DM_H, 32'h43, 32'h5555_AAAA, 1'b1);
      do_req(1'b0, DM_HU, 32'h43, 32'h0, 1'b1);
      do_req(1'b0, 3'd6, 32'h20, 32'h0, 1'b1);
      hold = 5;
      do_req(1'b1, DM_B, 32'h22, 32'h0000_0099, 1'b0);
      do_req(1'b0, DM_W, 32'h20, 32'h0, 1'b0);
      rsp_dly = 4;
      do_req(1'b0, DM_W, 32'h10, 32'h0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      chk("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (8) @(negedge clk);
      rsp_dly = 0;
      fast = 1'b0;
      repeat (300) begin
         a = $urandom_range(0, 63);
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FFC0);
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_resp_queue", exp_q.size(), 32'd0);
      chk("drain_mem_queue", mexp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
